// File: rtl/bg_band_renderer.sv
// Background band renderer: sky/ground fill plus VRAM-fetched band pixels (scroll via BG_SCROLL_EN).
// Latency: index_out/out_valid 2 cycles after pix_valid; index_out is muxed live from vram_rdata.
// Backpressure: none; every pix_valid cycle is accepted, and pix_valid low holds pointers and address.
module bg_band_renderer #(
    parameter logic [4:0] PALETTE   = 5'd0,
    parameter logic [9:0] SKY_END   = 10'd300,
    parameter logic [9:0] GND_START = 10'd428,
    parameter logic [3:0] SKY_IDX   = 4'd5,
    parameter logic [3:0] GND_IDX   = 4'd7,
    parameter int         WORD_W    = 9,
    parameter int         BPP       = 3,
    parameter int         WPL       = 214,
    parameter int         ADDR_W    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_valid,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              frame_start,
    input  logic              scroll_we,
    input  logic [7:0]        scroll_word,
    input  logic [1:0]        scroll_sub,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [WORD_W-1:0] vram_rdata,
    output logic [8:0]        index_out,
    output logic              out_valid
);

    localparam int PPW   = WORD_W / BPP;
    localparam int SUB_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(PPW - 1);
    localparam logic [ADDR_W-1:0] WORD_LAST = ADDR_W'(WPL - 1);
    localparam logic [1:0] RG_SKY  = 2'd0;
    localparam logic [1:0] RG_BAND = 2'd1;
    localparam logic [1:0] RG_GND  = 2'd2;

    logic [7:0] act_word;
    logic [1:0] act_sub;

`ifdef BG_SCROLL_EN
    logic [7:0] pend_word;
    logic [1:0] pend_sub;

    // A write landing with frame_start bypasses the pending stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_word <= '0;
            pend_sub  <= '0;
            act_word  <= '0;
            act_sub   <= '0;
        end else begin
            if (scroll_we) begin
                pend_word <= scroll_word;
                pend_sub  <= scroll_sub;
            end
            if (frame_start) begin
                act_word <= scroll_we ? scroll_word : pend_word;
                act_sub  <= scroll_we ? scroll_sub  : pend_sub;
            end
        end
    end
`else
    logic unused_scroll;
    assign act_word      = '0;
    assign act_sub       = '0;
    assign unused_scroll = ^{frame_start, scroll_we, scroll_word, scroll_sub};
`endif

    logic [ADDR_W-1:0] word_ptr, load_word, eff_word, nxt_word, band_addr;
    logic [SUB_W-1:0]  sub_ptr, load_sub, eff_sub, nxt_sub;
    logic [9:0]        band_row;
    logic [1:0]        rg;

    assign load_word = ADDR_W'(32'(act_word) % WPL);
    assign load_sub  = (32'(act_sub) >= PPW) ? SUB_LAST : SUB_W'(act_sub);

    always_comb begin
        rg = RG_GND;
        if (y < SKY_END)
            rg = RG_SKY;
        else if (y < GND_START)
            rg = RG_BAND;
    end

    assign band_row  = y - SKY_END;
    assign eff_word  = (x == 10'd0) ? load_word : word_ptr;
    assign eff_sub   = (x == 10'd0) ? load_sub  : sub_ptr;
    assign band_addr = ADDR_W'(band_row) * ADDR_W'(WPL) + eff_word;

    // Only band pixels consume VRAM fields; sky/ground just keep the loaded position.
    always_comb begin
        nxt_word = eff_word;
        nxt_sub  = eff_sub;
        if (rg == RG_BAND) begin
            if (eff_sub == SUB_LAST) begin
                nxt_sub  = '0;
                nxt_word = (eff_word == WORD_LAST) ? '0 : eff_word + ADDR_W'(1);
            end else begin
                nxt_sub = eff_sub + SUB_W'(1);
            end
        end
    end

    logic             v1, v2;
    logic [1:0]       r1, r2;
    logic [SUB_W-1:0] s1, s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_ptr  <= '0;
            sub_ptr   <= '0;
            vram_addr <= '0;
            v1        <= 1'b0;
            r1        <= RG_SKY;
            s1        <= '0;
            v2        <= 1'b0;
            r2        <= RG_SKY;
            s2        <= '0;
        end else begin
            v1 <= pix_valid;
            v2 <= v1;
            r2 <= r1;
            s2 <= s1;
            if (pix_valid) begin
                r1       <= rg;
                s1       <= eff_sub;
                word_ptr <= nxt_word;
                sub_ptr  <= nxt_sub;
                if (rg == RG_BAND)
                    vram_addr <= band_addr;
            end
        end
    end

    logic [BPP-1:0] field;

    // Field 0 is the most significant BPP bits of the word.
    always_comb begin
        field = '0;
        for (int i = 0; i < PPW; i++) begin
            if (s2 == SUB_W'(i))
                field = vram_rdata[WORD_W-1-i*BPP -: BPP];
        end
    end

    always_comb begin
        index_out = '0;
        if (v2) begin
            case (r2)
                RG_SKY:  index_out = {PALETTE, SKY_IDX};
                RG_BAND: index_out = {PALETTE, 4'(field)};
                default: index_out = {PALETTE, GND_IDX};
            endcase
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_bg_band_renderer.sv
// Bench for bg_band_renderer: constant vectors, directed scroll/reset sequences and a random run
// scored against a linear pixel-position model of the band.
module tb_bg_band_renderer;

    localparam int WORD_W    = 9;
    localparam int BPP       = 3;
    localparam int PPW       = 3;
    localparam int WPL       = 214;
    localparam int SKY_END   = 300;
    localparam int GND_START = 428;
    localparam logic [4:0] PAL = 5'd0;
    localparam logic [8:0] SKY_V = {PAL, 4'd5};
    localparam logic [8:0] GND_V = {PAL, 4'd7};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pix_valid;
    logic [9:0]  x, y;
    logic        frame_start, scroll_we;
    logic [7:0]  scroll_word;
    logic [1:0]  scroll_sub;
    logic [14:0] vram_addr;
    logic [8:0]  vram_rdata;
    logic [8:0]  index_out;
    logic        out_valid;

    bg_band_renderer dut (
        .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .x(x), .y(y),
        .frame_start(frame_start), .scroll_we(scroll_we), .scroll_word(scroll_word),
        .scroll_sub(scroll_sub), .vram_addr(vram_addr), .vram_rdata(vram_rdata),
        .index_out(index_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    logic [8:0] mem [0:32767];
    always @(posedge clk) vram_rdata <= mem[vram_addr];

    int checks = 0;
    int passed = 0;

    // Reference model: position within a line as a single pixel count.
    int          m_pos, m_pend_w, m_pend_s, m_act_w, m_act_s;
    logic [14:0] m_addr;
    logic        q_v [$];
    logic [8:0]  q_i [$];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pos = 0; m_pend_w = 0; m_pend_s = 0; m_act_w = 0; m_act_s = 0;
        m_addr = '0;
        q_v.delete();
        q_i.delete();
    endtask

    task automatic step(input logic pv, input int xx, input int yy,
                        input logic fs, input logic we, input int sw, input int ss);
        logic       ev, hv;
        logic [8:0] ei, hi, wordv;
        int         w, s, f;
        pix_valid = pv; x = 10'(xx); y = 10'(yy);
        frame_start = fs; scroll_we = we; scroll_word = 8'(sw); scroll_sub = 2'(ss);
        ev = pv; ei = '0;
        if (pv) begin
            if (xx == 0) m_pos = (m_act_w % WPL) * PPW + ((m_act_s >= PPW) ? PPW - 1 : m_act_s);
            if (yy < SKY_END) ei = SKY_V;
            else if (yy >= GND_START) ei = GND_V;
            else begin
                w = m_pos / PPW;
                s = m_pos % PPW;
                m_addr = 15'((yy - SKY_END) * WPL + w);
                wordv = mem[m_addr];
                f = (int'(wordv) >> (WORD_W - (s + 1) * BPP)) & ((1 << BPP) - 1);
                ei = {PAL, 4'(f)};
                m_pos = (m_pos + 1) % (WPL * PPW);
            end
        end
`ifdef BG_SCROLL_EN
        if (fs) begin
            m_act_w = we ? sw : m_pend_w;
            m_act_s = we ? ss : m_pend_s;
        end
        if (we) begin
            m_pend_w = sw;
            m_pend_s = ss;
        end
`endif
        q_v.push_back(ev);
        q_i.push_back(ei);
        @(posedge clk); #1;
        check("vram_addr", 32'(vram_addr), 32'(m_addr));
        if (q_v.size() == 2) begin
            hv = q_v.pop_front();
            hi = q_i.pop_front();
        end else begin
            hv = 1'b0;
            hi = '0;
        end
        check("out_valid", 32'(out_valid), 32'(hv));
        if (hv) check("index_out", 32'(index_out), 32'(hi));
    endtask

    task automatic idle();
        step(1'b0, 1, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        pix_valid = 0; x = '0; y = '0; frame_start = 0; scroll_we = 0;
        scroll_word = '0; scroll_sub = '0;
        rst_n = 1'b0;
        #1;
        check("rst_index", 32'(index_out), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_addr", 32'(vram_addr), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        int         xx;
        int         yy;
        logic [8:0] idx;
    } vec_t;

    vec_t        tbl [6];
    logic [14:0] addr_before;

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 9'($urandom);
        tbl[0] = '{5, 100, 9'h005};
        tbl[1] = '{1, 0, 9'h005};
        tbl[2] = '{7, 299, 9'h005};
        tbl[3] = '{3, 428, 9'h007};
        tbl[4] = '{9, 500, 9'h007};
        tbl[5] = '{2, 1023, 9'h007};
        do_reset();

        // Sky and ground produce constant indices and leave the address alone.
        for (int i = 0; i < 6; i++) begin
            addr_before = vram_addr;
            step(1'b1, tbl[i].xx, tbl[i].yy, 1'b0, 1'b0, 0, 0);
            idle();
            check("tbl_valid", 32'(out_valid), 1);
            check("tbl_index", 32'(index_out), 32'(tbl[i].idx));
            check("tbl_addr_hold", 32'(vram_addr), 32'(addr_before));
        end

        // First band line, zero scroll.
        mem[0] = 9'o123;
        mem[1] = 9'o456;
        step(1'b1, 0, 300, 1'b0, 1'b0, 0, 0);
        check("band_addr0", 32'(vram_addr), 0);
        step(1'b1, 1, 300, 1'b0, 1'b0, 0, 0);
        check("band_px0", 32'(index_out), 32'h001);
        step(1'b1, 2, 300, 1'b0, 1'b0, 0, 0);
        check("band_px1", 32'(index_out), 32'h002);
        step(1'b1, 3, 300, 1'b0, 1'b0, 0, 0);
        check("band_px2", 32'(index_out), 32'h003);
        check("band_addr_x3", 32'(vram_addr), 1);
        idle();
        check("band_px3", 32'(index_out), 32'h004);
        idle();

        // Scroll to the last word and sub 2, then wrap to word 0.
        mem[427] = 9'o765;
        mem[214] = 9'o432;
        step(1'b0, 1, 0, 1'b0, 1'b1, 213, 2);
        step(1'b0, 1, 0, 1'b1, 1'b0, 0, 0);
        step(1'b1, 0, 301, 1'b0, 1'b0, 0, 0);
`ifdef BG_SCROLL_EN
        check("wrap_addr0", 32'(vram_addr), 427);
`else
        check("wrap_addr0", 32'(vram_addr), 214);
`endif
        step(1'b1, 1, 301, 1'b0, 1'b0, 0, 0);
        check("wrap_addr1", 32'(vram_addr), 214);
`ifdef BG_SCROLL_EN
        check("wrap_px0", 32'(index_out), 32'h005);
`else
        check("wrap_px0", 32'(index_out), 32'h004);
`endif
        idle();
`ifdef BG_SCROLL_EN
        check("wrap_px1", 32'(index_out), 32'h004);
`else
        check("wrap_px1", 32'(index_out), 32'h003);
`endif
        idle();

        // Same-cycle write and frame_start; a later lone write stays pending.
        step(1'b0, 1, 0, 1'b1, 1'b1, 4, 0);
        step(1'b1, 0, 300, 1'b0, 1'b0, 0, 0);
`ifdef BG_SCROLL_EN
        check("bypass_addr", 32'(vram_addr), 4);
`else
        check("bypass_addr", 32'(vram_addr), 0);
`endif
        step(1'b0, 1, 0, 1'b0, 1'b1, 9, 1);
        addr_before = vram_addr;
        step(1'b1, 0, 300, 1'b0, 1'b0, 0, 0);
        check("pending_addr", 32'(vram_addr), 32'(addr_before));
        idle();
        idle();

        // Reset with two band pixels in flight: neither may surface.
        pix_valid = 1'b1; x = 10'd0; y = 10'd310;
        @(posedge clk); #1;
        x = 10'd1;
        #2 rst_n = 1'b0;
        @(posedge clk); #2;
        check("inflight_valid_rst", 32'(out_valid), 0);
        rst_n = 1'b1;
        pix_valid = 1'b0;
        model_reset();
        check("inflight_addr", 32'(vram_addr), 0);
        for (int i = 0; i < 3; i++) idle();
        step(1'b1, 4, 350, 1'b0, 1'b0, 0, 0);
        idle();
        check("post_rst_valid", 32'(out_valid), 1);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            int yy, xx, r;
            logic pv, fs, we;
            r = int'($urandom_range(0, 5));
            case (r)
                0: yy = int'($urandom_range(0, 299));
                4: yy = int'($urandom_range(428, 524));
                5: begin
                    r = int'($urandom_range(0, 3));
                    yy = (r == 0) ? 299 : (r == 1) ? 300 : (r == 2) ? 427 : 428;
                end
                default: yy = int'($urandom_range(300, 427));
            endcase
            xx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 639));
            pv = ($urandom_range(0, 3) != 0);
            fs = ($urandom_range(0, 40) == 0);
            we = ($urandom_range(0, 25) == 0);
            step(pv, xx, yy, fs, we, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bg_band_renderer.md
BG_BAND_RENDERER -- requirements
Module: bg_band_renderer

Interface
REQ-001 Parameter PALETTE, 5'd0: palette select placed in index_out[8:4].
REQ-002 Parameter SKY_END, 10'd300: first band line; y < SKY_END is sky.
REQ-003 Parameter GND_START, 10'd428: first ground line; y >= GND_START is ground.
REQ-004 Parameter SKY_IDX, 4'd5 and GND_IDX, 4'd7: colour index for the sky and ground regions.
REQ-005 Parameter WORD_W, 9 and BPP, 3: VRAM word width and bits per pixel; PPW = WORD_W/BPP pixels per word, with WORD_W an exact multiple of BPP and BPP in 1..4.
REQ-006 Parameter WPL, 214: VRAM words per band line; ADDR_W, 15: VRAM address width.
REQ-007 Port clk, in, 1: the only clock; all state updates on its rising edge.
REQ-008 Port rst_n, in, 1: reset, asynchronous and active-low.
REQ-009 Port pix_valid, in, 1: the x/y pair is a pixel to render this cycle.
REQ-010 Port x, in, 10 and y, in, 10: current pixel coordinates.
REQ-011 Port frame_start, in, 1: one-cycle pulse before line 0 of a frame.
REQ-012 Port scroll_we, in, 1, with scroll_word, in, 8 and scroll_sub, in, 2: pending horizontal scroll write.
REQ-013 Port vram_addr, out, ADDR_W: registered read address to the external band VRAM.
REQ-014 Port vram_rdata, in, WORD_W: VRAM read data, valid exactly 1 cycle after vram_addr.
REQ-015 Port index_out, out, 9 and out_valid, out, 1: the rendered palette index and its qualifier.

Function
REQ-016 Region decode: sky if y < SKY_END; band if SKY_END <= y < GND_START; otherwise ground.
REQ-017 Fixed latency: index_out and out_valid appear exactly 2 cycles after the accepting pix_valid cycle, and out_valid equals pix_valid delayed by 2.
REQ-018 Sky output is {PALETTE, SKY_IDX}; ground output is {PALETTE, GND_IDX}; neither region issues a VRAM read.
REQ-019 Line start is pix_valid with x == 0.
  - word_ptr loads act_word mod WPL; sub_ptr loads act_sub.
  - Line start overrides any pointer state, including mid-line.
REQ-020 Each pix_valid cycle in the band:
  - vram_addr <= (y - SKY_END)*WPL + word_ptr.
  - After use, sub_ptr increments.
  - When sub_ptr == PPW-1, sub_ptr wraps to 0 and word_ptr increments, wrapping from WPL-1 to 0.
REQ-021 Cycles with pix_valid low hold word_ptr, sub_ptr and vram_addr.
REQ-022 Pixel field select: field k (k = registered sub_ptr) is vram_rdata[WORD_W-1-k*BPP -: BPP], MSB first. The field is zero-extended to 4 bits as index_out[3:0], with index_out[8:4] = PALETTE.
REQ-023 An act_sub value >= PPW is clamped to PPW-1 when loaded.
REQ-024 Scroll is double-buffered:
  - scroll_we loads pend_word/pend_sub.
  - frame_start copies pend into act_word/act_sub.
  - scroll_we and frame_start in the same cycle: the newly written value goes directly to act.
REQ-025 Address arithmetic is unsigned and truncated to ADDR_W bits; band row = y - SKY_END, evaluated only inside the band.

Reset
REQ-026 While rst_n is low, all of the following are 0 regardless of clk:
  - index_out and out_valid;
  - vram_addr;
  - word_ptr and sub_ptr;
  - pend and act scroll;
  - all pipeline valid bits.
REQ-027 On rst_n deassertion, the first output is produced 2 cycles after the first pix_valid.
  - In-flight pixels from before reset are discarded and never appear.

Configuration
REQ-028 Macro BG_SCROLL_EN defined:
  - REQ-012 and REQ-024 apply as written.
  - Macro undefined: scroll registers are absent, act_word = act_sub = 0, and scroll_we, scroll_word and scroll_sub are ignored.

Verification
REQ-029 y=100, x=5, pix_valid=1 -> 2 cycles later index_out=9'h005, out_valid=1; vram_addr unchanged.
REQ-030 y=500 -> index_out=9'h007 after 2 cycles.
REQ-031 Band first line, scroll 0:
  - Stimulus: y=300, x=0..2 consecutive; vram_rdata=9'o123 on the cycle after vram_addr=0.
  - Response: index_out 9'h001, 9'h002, 9'h003; x=3 gives vram_addr=1.
REQ-032 Scroll wrap:
  - Stimulus: scroll_we with word=213, sub=2, then frame_start; y=301, x=0,1.
  - Response: vram_addr=214+213=427, field 2 selected; x=1 gives vram_addr=214 (word wrap to 0).
REQ-033 Scroll write and frame_start in the same cycle, word=4 -> next line start uses act_word=4; a later scroll_we without frame_start does not change the address.
REQ-034 rst_n low for 1 cycle while two band pixels are in flight -> out_valid stays 0 for those pixels, and vram_addr=0 after reset.
